// File: rtl/serial_borrow_subtractor_if.sv
// rtl/serial_borrow_subtractor_if.sv - operand/result bundle for the bit-serial subtractor
//
// Purpose: groups the start/done handshake, the operand inputs and the
// registered result outputs of serial_borrow_subtractor into one port.
//
// Signals:
//   start  requester -> subtractor  request a new operation
//   a      requester -> subtractor  minuend (WIDTH bits)
//   b      requester -> subtractor  subtrahend (WIDTH bits)
//   bin    requester -> subtractor  borrow-in
//   busy   subtractor -> requester  serial operation in progress
//   done   subtractor -> requester  one-cycle result-valid pulse
//   diff   subtractor -> requester  difference (WIDTH bits), held
//   bout   subtractor -> requester  borrow-out, held
//   ovf    subtractor -> requester  signed overflow, held
//
// Modports: master = requester side, slave = subtractor side.

interface serial_borrow_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_borrow_subtractor.sv
// rtl/serial_borrow_subtractor.sv - bit-serial a - b - bin with registered borrow
//
// Purpose: computes {bout, diff} = {1'b0, a} - b - bin one bit per clock,
// LSB first. An accepted start latches the operands; WIDTH SHIFT cycles
// follow, then a single DONE cycle in which done pulses. diff, bout and ovf
// are updated only on the edge entering DONE (or cleared by reset) and are
// held otherwise. A start seen in DONE chains straight into the next SHIFT,
// giving one result per WIDTH+1 cycles.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of serial_borrow_subtractor_if
//          (start/a/b/bin in; busy/done/diff/bout/ovf out)

module serial_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  serial_borrow_subtractor_if.slave   bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;

  // Operand shift registers: the bit being processed is always at [0].
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Partial result: each new bit enters at the MSB and moves down, so after
  // WIDTH shifts bit i sits at position i.
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Operand sign bits are shifted out of a_q/b_q, so keep copies for ovf.
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Full-subtractor cell for the current bit.
  logic bit_a;
  logic bit_b;
  logic d_bit;
  logic brw_next;

  assign bit_a    = a_q[0];
  assign bit_b    = b_q[0];
  assign d_bit    = bit_a ^ bit_b ^ brw_q;
  assign brw_next = (~bit_a & bit_b) | (~bit_a & brw_q) | (bit_b & brw_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SHIFT;
          a_d     = bus.a;
          b_d     = bus.b;
          brw_d   = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
        end
      end

      S_SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {d_bit, res_q[WIDTH-1:1]};
        brw_d = brw_next;
        if (cnt_q == LAST_BIT) begin
          // Last bit: publish the result on the edge that enters DONE.
          // The counter is left at its final value rather than wrapping.
          state_d = S_DONE;
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = brw_next;
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (bus.start) begin
          state_d = S_SHIFT;
          a_d     = bus.a;
          b_d     = bus.b;
          brw_d   = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == S_SHIFT);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/serial_borrow_subtractor.md
Name: serial_borrow_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first, using a registered borrow.
- Counterpart to the team's combinational carry adders.
- Serves area-constrained datapaths where multi-cycle latency is acceptable.
- Start/done handshake; the result is held stable until the next accepted operation.

Parameters:
WIDTH, 4, operand and result width in bits (minimum 2)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request a new operation; sampled on the rising edge
a      input   WIDTH  minuend; sampled only when start is accepted
b      input   WIDTH  subtrahend; sampled only when start is accepted
bin    input   1      borrow-in; sampled only when start is accepted
busy   output  1      high while the serial operation is in progress (SHIFT state)
done   output  1      registered; one-cycle pulse when a result becomes valid
diff   output  WIDTH  registered difference, held until the next completion
bout   output  1      registered borrow-out (1 = unsigned underflow)
ovf    output  1      registered signed-overflow flag for two's-complement operands

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately.
  - busy=0, done=0, diff=0, bout=0, ovf=0.
  - Internal shift registers, borrow register and bit counter are cleared.
  - An operation in flight is abandoned; no done is issued for it.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - start=1 at an edge: latch a, b and bin into internal registers; counter=0; next state SHIFT.
- SHIFT (busy=1), at each edge:
  - Bit i = counter is processed:
    - d_i = a_i ^ b_i ^ brw
    - brw_next = (~a_i & b_i) | (~a_i & brw) | (b_i & brw)
  - d_i is shifted into the result register from the MSB side, so bit i lands at position i after WIDTH shifts.
  - counter increments.
  - When counter == WIDTH-1 is processed, next state is DONE.
  - start is ignored while in SHIFT.
- DONE (lasts one cycle):
  - done=1, busy=0.
  - diff, bout and ovf updated on the same edge that enters DONE.
  - bout = final borrow.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the latched operands. bin does not enter the overflow formula.
  - Next state: SHIFT if start=1 at the DONE edge (back-to-back, new operands latched); otherwise IDLE.
- Latency:
  - start accepted at edge E0.
  - done is high in the cycle following edge E(WIDTH).
  - Throughput is one result per WIDTH+1 cycles, including back-to-back operation.
- Output hold: diff, bout and ovf change only on entry to DONE or on reset. They stay stable in IDLE and during a subsequent SHIFT.
- Arithmetic: the result is modulo 2^WIDTH. Equivalently, {bout, diff} = {1'b0, a} - b - bin, taken as a (WIDTH+1)-bit two's-complement value.
- Boundaries:
  - a=b, bin=0 gives diff=0, bout=0.
  - a=0, b=0, bin=1 gives diff=all-ones, bout=1.
  - Maximum underflow (a=0, b=all-ones, bin=1) gives diff=0, bout=1.
  - The counter never wraps; it is reloaded on each accepted start.
- Reset deasserted mid-cycle: the block stays in IDLE until the next start.

Test Plan:
- WIDTH=4; a=9, b=5, bin=0, start pulse at E0 -> busy for 4 cycles; done in the cycle after E4; diff=4, bout=0, ovf=0.
- a=5, b=9, bin=0 -> diff=12 (4'b1100), bout=1, ovf=1 (5 - (-7) = 12 overflows signed 4-bit). Then a=8, b=1, bin=0 -> diff=7, bout=0, ovf=1 (-8-1 overflows).
- a=0, b=0, bin=1 -> diff=15, bout=1, ovf=0. Then a=0, b=15, bin=1 -> diff=0, bout=1.
- start held high continuously with a new operand each accepted start -> done every 5 cycles; inputs changed or start pulsed while busy=1 have no effect on the in-flight result.
- rst_n driven low during the 3rd SHIFT cycle -> all outputs 0 immediately; no done pulse; after release a fresh 7-3 produces diff=4, bout=0.
- After completion, hold start=0 for 10 cycles while toggling a/b -> diff, bout and ovf unchanged; done is a single-cycle pulse.
